// File: rtl/row_sweep_scheduler.sv
// Row-at-a-time sweep of the light grid: replays the instruction buffer per row,
// forwards covering spans to the row datapath and accumulates row sums.
// Optional build macro ROW_SWEEP_SATURATE_EN makes the accumulator saturate instead of wrap.
module row_sweep_scheduler #(
  parameter int INSTRUCTION_WIDTH = 50,
  parameter int POS_WIDTH         = 12,
  parameter int GRID_SIZE         = 1000,
  parameter int ROW_SUM_WIDTH     = 16,
  parameter int RESULT_WIDTH      = 24
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  output logic                         instr_rewind,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic                         instr_last,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_data,
  output logic                         row_clear,
  input  logic                         row_idle,
  output logic                         span_valid,
  input  logic                         span_ready,
  output logic [1:0]                   span_op,
  output logic [POS_WIDTH-1:0]         span_x_lo,
  output logic [POS_WIDTH-1:0]         span_x_hi,
  output logic                         sum_req,
  input  logic                         sum_valid,
  input  logic [ROW_SUM_WIDTH-1:0]     sum_data,
  output logic [POS_WIDTH-1:0]         row_index,
  output logic                         count_done,
  output logic [RESULT_WIDTH-1:0]      count_value
);

  typedef enum logic [3:0] {
    S_IDLE, S_REWIND, S_REWIND_WAIT, S_CLEAR, S_CLEAR_WAIT,
    S_FETCH, S_ISSUE, S_SUM_REQ, S_SUM_WAIT, S_DONE
  } state_e;

  localparam logic [POS_WIDTH-1:0] LAST_ROW = POS_WIDTH'(GRID_SIZE - 1);
  localparam logic [POS_WIDTH-1:0] ROW_ONE  = POS_WIDTH'(1);

  state_e                  state_q;
  logic                    instr_rewind_q, instr_ready_q, row_clear_q;
  logic                    span_valid_q, sum_req_q, count_done_q, last_q;
  logic [1:0]              span_op_q;
  logic [POS_WIDTH-1:0]    span_x_lo_q, span_x_hi_q, row_index_q;
  logic [RESULT_WIDTH-1:0] count_value_q, count_d;

  logic [1:0]           op_s;
  logic [POS_WIDTH-1:0] xs_s, ys_s, xe_s, ye_s, xlo_s, xhi_s, ylo_s, yhi_s;
  logic                 hit_s;

  assign op_s  = instr_data[4*POS_WIDTH+1 -: 2];
  assign xs_s  = instr_data[4*POS_WIDTH-1 -: POS_WIDTH];
  assign ys_s  = instr_data[3*POS_WIDTH-1 -: POS_WIDTH];
  assign xe_s  = instr_data[2*POS_WIDTH-1 -: POS_WIDTH];
  assign ye_s  = instr_data[POS_WIDTH-1 -: POS_WIDTH];
  // Corners may arrive in either order; normalise before the row test.
  assign xlo_s = (xs_s <= xe_s) ? xs_s : xe_s;
  assign xhi_s = (xs_s <= xe_s) ? xe_s : xs_s;
  assign ylo_s = (ys_s <= ye_s) ? ys_s : ye_s;
  assign yhi_s = (ys_s <= ye_s) ? ye_s : ys_s;
  assign hit_s = (ylo_s <= row_index_q) && (row_index_q <= yhi_s) && (op_s != 2'd3);

`ifdef ROW_SWEEP_SATURATE_EN
  localparam int SUM_W = ((RESULT_WIDTH > ROW_SUM_WIDTH) ? RESULT_WIDTH : ROW_SUM_WIDTH) + 1;
  logic [SUM_W-1:0] acc_wide_s;
  logic             ovf_s, ovf_q;
  logic [7:0]       dbg_s;
  assign acc_wide_s = SUM_W'(count_value_q) + SUM_W'(sum_data);
  assign ovf_s      = |acc_wide_s[SUM_W-1:RESULT_WIDTH];
  assign dbg_s      = {7'd0, ovf_q};
  // Saturating accumulate: clamp to all-ones when the wide sum spills over.
  always_comb begin
    count_d = acc_wide_s[RESULT_WIDTH-1:0];
    if (ovf_s) begin
      count_d = {RESULT_WIDTH{1'b1}};
    end else begin
      count_d = acc_wide_s[RESULT_WIDTH-1:0];
    end
  end
`else
  // Wrapping accumulate of the zero-extended row sum.
  always_comb begin
    count_d = count_value_q + RESULT_WIDTH'(sum_data);
  end
`endif

  // Sweep FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      instr_rewind_q <= 1'b0;
      instr_ready_q  <= 1'b0;
      row_clear_q    <= 1'b0;
      span_valid_q   <= 1'b0;
      span_op_q      <= 2'd0;
      span_x_lo_q    <= '0;
      span_x_hi_q    <= '0;
      sum_req_q      <= 1'b0;
      row_index_q    <= '0;
      count_done_q   <= 1'b0;
      count_value_q  <= '0;
      last_q         <= 1'b0;
`ifdef ROW_SWEEP_SATURATE_EN
      ovf_q          <= 1'b0;
`endif
    end else begin
      instr_rewind_q <= 1'b0;
      row_clear_q    <= 1'b0;
      sum_req_q      <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            count_value_q  <= '0;
            count_done_q   <= 1'b0;
            row_index_q    <= '0;
            instr_rewind_q <= 1'b1;
            state_q        <= S_REWIND;
          end
        end
        S_REWIND:      state_q <= S_REWIND_WAIT;
        S_REWIND_WAIT: begin
          row_clear_q <= 1'b1;
          state_q     <= S_CLEAR;
        end
        S_CLEAR:       state_q <= S_CLEAR_WAIT;
        S_CLEAR_WAIT: begin
          if (row_idle) begin
            instr_ready_q <= 1'b1;
            state_q       <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (instr_valid && hit_s) begin
            span_op_q     <= op_s;
            span_x_lo_q   <= xlo_s;
            span_x_hi_q   <= xhi_s;
            last_q        <= instr_last;
            span_valid_q  <= 1'b1;
            instr_ready_q <= 1'b0;
            state_q       <= S_ISSUE;
          end else if (instr_valid && instr_last) begin
            instr_ready_q <= 1'b0;
            state_q       <= S_SUM_REQ;
          end
        end
        S_ISSUE: begin
          if (span_ready) begin
            span_valid_q <= 1'b0;
            if (last_q) begin
              state_q <= S_SUM_REQ;
            end else begin
              instr_ready_q <= 1'b1;
              state_q       <= S_FETCH;
            end
          end
        end
        S_SUM_REQ: begin
          if (row_idle) begin
            sum_req_q <= 1'b1;
            state_q   <= S_SUM_WAIT;
          end
        end
        S_SUM_WAIT: begin
          if (sum_valid) begin
            count_value_q <= count_d;
`ifdef ROW_SWEEP_SATURATE_EN
            ovf_q         <= ovf_q | ovf_s;
`endif
            if (row_index_q == LAST_ROW) begin
              count_done_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              row_index_q    <= row_index_q + ROW_ONE;
              instr_rewind_q <= 1'b1;
              state_q        <= S_REWIND;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_rewind = instr_rewind_q;
  assign instr_ready  = instr_ready_q;
  assign row_clear    = row_clear_q;
  assign span_valid   = span_valid_q;
  assign span_op      = span_op_q;
  assign span_x_lo    = span_x_lo_q;
  assign span_x_hi    = span_x_hi_q;
  assign sum_req      = sum_req_q;
  assign row_index    = row_index_q;
  assign count_done   = count_done_q;
  assign count_value  = count_value_q;

endmodule

// File: tb/tb_row_sweep_scheduler.sv
// Directed bench for row_sweep_scheduler with a 4-row grid and an 8-bit total.
module tb_row_sweep_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        instr_rewind, instr_ready, row_clear, span_valid, sum_req, count_done;
  logic        instr_valid, instr_last;
  logic [49:0] instr_data;
  logic        row_idle = 1'b1;
  logic        span_ready = 1'b1;
  logic [1:0]  span_op;
  logic [11:0] span_x_lo, span_x_hi, row_index;
  logic        sum_valid = 1'b0;
  logic [15:0] sum_data = 16'd0;
  logic [7:0]  count_value;

  int n_checks = 0;
  int n_fail   = 0;

  logic [49:0] prog [0:3];
  int          prog_n = 0;
  int          rd_ptr = 0;
  logic [15:0] sum_tbl [0:3];
  int          rewinds = 0;

  typedef struct packed {
    logic [11:0] row;
    logic [1:0]  op;
    logic [11:0] lo;
    logic [11:0] hi;
  } span_t;
  span_t spans[$];

  row_sweep_scheduler #(.GRID_SIZE(4), .RESULT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .instr_rewind(instr_rewind), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_last(instr_last), .instr_data(instr_data),
    .row_clear(row_clear), .row_idle(row_idle),
    .span_valid(span_valid), .span_ready(span_ready), .span_op(span_op),
    .span_x_lo(span_x_lo), .span_x_hi(span_x_hi),
    .sum_req(sum_req), .sum_valid(sum_valid), .sum_data(sum_data),
    .row_index(row_index), .count_done(count_done), .count_value(count_value)
  );

  always #5 clk = ~clk;

  // Instruction buffer stub.
  assign instr_valid = (rd_ptr < prog_n);
  assign instr_data  = prog[rd_ptr[1:0]];
  assign instr_last  = (rd_ptr == prog_n - 1);
  always @(posedge clk) begin
    if (instr_rewind) rd_ptr <= 0;
    else if (instr_valid && instr_ready) rd_ptr <= rd_ptr + 1;
  end

  // Row-sum stub answers one cycle after the request; monitor logs rewinds and spans.
  always @(posedge clk) begin
    sum_valid <= sum_req;
    sum_data  <= sum_tbl[row_index[1:0]];
    if (instr_rewind) rewinds <= rewinds + 1;
    if (span_valid && span_ready) spans.push_back({row_index, span_op, span_x_lo, span_x_hi});
  end

  function automatic logic [49:0] enc(input logic [1:0] op, input logic [11:0] xs,
                                      input logic [11:0] ys, input logic [11:0] xe,
                                      input logic [11:0] ye);
    return {op, xs, ys, xe, ye};
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (count_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_span_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (span_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    int rw0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({instr_rewind, instr_ready, row_clear, span_valid, span_op, span_x_lo, span_x_hi,
         sum_req, row_index, count_done, count_value} !== 52'd0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero, row_index=%0d count=%0d (want 0)", row_index, count_value);
    end
    reset_n = 1'b1;
    rw0 = rewinds;
    repeat (4) @(negedge clk);
    n_checks++;
    if (rewinds - rw0 !== 0 || instr_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: rewinds=%0d ready=%b (want 0,0)", rewinds - rw0, instr_ready);
    end
  endtask

  task automatic test_smoke();
    bit ok; int rw0, sp0;
    prog[0] = enc(2'd1, 12'd0, 12'd0, 12'd2, 12'd1); prog_n = 1;
    sum_tbl[0] = 16'd3; sum_tbl[1] = 16'd3; sum_tbl[2] = 16'd0; sum_tbl[3] = 16'd0;
    rw0 = rewinds; sp0 = spans.size();
    pulse_start();
    wait_done(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL smoke_timeout: count_done=0 (want 1)"); end
    n_checks++;
    if (count_value !== 8'd6) begin n_fail++; $display("FAIL smoke_total: got %0d want 6", count_value); end
    n_checks++;
    if (rewinds - rw0 !== 4) begin n_fail++; $display("FAIL smoke_rewinds: got %0d want 4", rewinds - rw0); end
    n_checks++;
    if (row_index !== 12'd3) begin n_fail++; $display("FAIL smoke_row_index: got %0d want 3", row_index); end
    n_checks++;
    if (spans.size() - sp0 !== 2) begin
      n_fail++; $display("FAIL smoke_span_count: got %0d want 2", spans.size() - sp0);
    end else begin
      for (int r = 0; r < 2; r++) begin
        n_checks++;
        if (spans[sp0 + r] !== {12'(r), 2'd1, 12'd0, 12'd2}) begin
          n_fail++; $display("FAIL smoke_span%0d: got %h want row %0d (1,0,2)", r, spans[sp0 + r], r);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok; int sp0;
    prog[0] = enc(2'd0, 12'd7, 12'd0, 12'd9, 12'd0); prog_n = 1;
    for (int i = 0; i < 4; i++) sum_tbl[i] = 16'd0;
    sp0 = spans.size();
    span_ready = 1'b0;
    pulse_start();
    wait_span_valid(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_span_timeout: span_valid=0 (want 1)"); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({span_valid, span_op, span_x_lo, span_x_hi} !== {1'b1, 2'd0, 12'd7, 12'd9}) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b op=%0d lo=%0d hi=%0d want 1,0,7,9", c, span_valid, span_op, span_x_lo, span_x_hi);
      end
    end
    span_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (span_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: span_valid=%b want 0", span_valid); end
    wait_done(ok);
    n_checks++;
    if (!ok || spans.size() - sp0 !== 1) begin
      n_fail++; $display("FAIL bp_span_count: done=%b spans=%0d want 1,1", ok, spans.size() - sp0);
    end
  endtask

  task automatic test_filter();
    bit ok; int sp0;
    prog[0] = enc(2'd3, 12'd0, 12'd0, 12'd9, 12'd3);
    prog[1] = enc(2'd2, 12'd5, 12'd3, 12'd2, 12'd1); prog_n = 2;
    sum_tbl[0] = 16'd1; sum_tbl[1] = 16'd2; sum_tbl[2] = 16'd3; sum_tbl[3] = 16'd4;
    sp0 = spans.size();
    pulse_start();
    wait_done(ok);
    n_checks++;
    if (!ok || count_value !== 8'd10) begin
      n_fail++; $display("FAIL filter_total: done=%b got %0d want 1,10", ok, count_value);
    end
    n_checks++;
    if (spans.size() - sp0 !== 3) begin
      n_fail++; $display("FAIL filter_span_count: got %0d want 3", spans.size() - sp0);
    end else begin
      for (int r = 0; r < 3; r++) begin
        n_checks++;
        if (spans[sp0 + r] !== {12'(r + 1), 2'd2, 12'd2, 12'd5}) begin
          n_fail++; $display("FAIL filter_span%0d: got %h want row %0d (2,2,5)", r, spans[sp0 + r], r + 1);
        end
      end
    end
  endtask

  task automatic test_start_handling();
    bit ok; int rw0;
    prog[0] = enc(2'd1, 12'd0, 12'd0, 12'd2, 12'd1); prog_n = 1;
    sum_tbl[0] = 16'd3; sum_tbl[1] = 16'd3; sum_tbl[2] = 16'd0; sum_tbl[3] = 16'd0;
    rw0 = rewinds;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (instr_ready) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL start_fetch_timeout: instr_ready=0 want 1"); end
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(ok);
    n_checks++;
    if (!ok || count_value !== 8'd6 || rewinds - rw0 !== 4) begin
      n_fail++; $display("FAIL start_ignored: done=%b total=%0d rewinds=%0d want 1,6,4", ok, count_value, rewinds - rw0);
    end
    rw0 = rewinds;
    pulse_start();
    n_checks++;
    if ({count_done, row_index, count_value} !== 21'd0) begin
      n_fail++; $display("FAIL restart_clear: done=%b row=%0d total=%0d want 0,0,0", count_done, row_index, count_value);
    end
    wait_done(ok);
    n_checks++;
    if (!ok || count_value !== 8'd6 || rewinds - rw0 !== 4) begin
      n_fail++; $display("FAIL restart_total: done=%b total=%0d rewinds=%0d want 1,6,4", ok, count_value, rewinds - rw0);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit ok; int rw0;
    prog[0] = enc(2'd1, 12'd7, 12'd0, 12'd9, 12'd0); prog_n = 1;
    span_ready = 1'b0;
    pulse_start();
    wait_span_valid(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midrst_span_timeout: span_valid=0 want 1"); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({instr_rewind, instr_ready, row_clear, span_valid, span_op, span_x_lo, span_x_hi,
         sum_req, row_index, count_done, count_value} !== 52'd0) begin
      n_fail++; $display("FAIL midrst_outputs: v=%b op=%0d lo=%0d hi=%0d want all 0", span_valid, span_op, span_x_lo, span_x_hi);
    end
    span_ready = 1'b1;
    @(negedge clk) reset_n = 1'b1;
    rw0 = rewinds;
    repeat (20) @(negedge clk);
    n_checks++;
    if (rewinds - rw0 !== 0 || instr_ready !== 1'b0 || span_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_idle: rewinds=%0d ready=%b valid=%b want 0,0,0", rewinds - rw0, instr_ready, span_valid);
    end
  endtask

  task automatic test_accumulation();
    bit ok; logic [7:0] want;
`ifdef ROW_SWEEP_SATURATE_EN
    want = 8'd255;
`else
    want = 8'd144;
`endif
    prog[0] = enc(2'd1, 12'd0, 12'd0, 12'd2, 12'd1); prog_n = 1;
    sum_tbl[0] = 16'd200; sum_tbl[1] = 16'd200; sum_tbl[2] = 16'd0; sum_tbl[3] = 16'd0;
    pulse_start();
    wait_done(ok);
    n_checks++;
    if (!ok || count_value !== want) begin
      n_fail++; $display("FAIL accum_limit: done=%b got %0d want 1,%0d", ok, count_value, want);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      prog[i]    = 50'd0;
      sum_tbl[i] = 16'd0;
    end
    test_reset();
    test_smoke();
    test_backpressure();
    test_filter();
    test_start_handling();
    test_reset_mid_sweep();
    test_accumulation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/row_sweep_scheduler.md
Name: row_sweep_scheduler

Overview:
- Sequences the day-6 part-2 light grid one row at a time.
- For each row it rewinds the instruction buffer and replays every instruction. Instructions that cover the row are sent to a one-row brightness datapath as column spans; the rest are dropped.
- After each row it reads back the row brightness sum and adds it to a running total.
- Sits in the conf_clk domain, between the instruction buffer read port and the row datapath. It replaces a full-grid display engine.

Parameters:
- INSTRUCTION_WIDTH, 50, instruction bits: 2-bit op followed by four POS_WIDTH coordinates.
- POS_WIDTH, 12, width of each coordinate.
- GRID_SIZE, 1000, number of rows swept, 0..GRID_SIZE-1.
- ROW_SUM_WIDTH, 16, width of the row sum returned by the datapath.
- RESULT_WIDTH, 24, width of the accumulated total.

Ports:
- clk  in  1  conf_clk domain clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a sweep; ignored unless in IDLE or DONE.
- instr_rewind  out  1  one-cycle pulse that resets the buffer read pointer to entry 0.
- instr_valid  in  1  buffer read beat is valid.
- instr_ready  out  1  scheduler accepts the beat.
- instr_last  in  1  beat is the final instruction.
- instr_data  in  INSTRUCTION_WIDTH  {op[49:48], x_start[47:36], y_start[35:24], x_end[23:12], y_end[11:0]}.
- row_clear  out  1  one-cycle pulse that zeroes the row datapath.
- row_idle  in  1  datapath has finished its clear or its last span.
- span_valid  out  1  span command is valid.
- span_ready  in  1  datapath accepts the span.
- span_op  out  2  op code: 0 = off, 1 = on, 2 = toggle.
- span_x_lo  out  POS_WIDTH  first column, inclusive.
- span_x_hi  out  POS_WIDTH  last column, inclusive.
- sum_req  out  1  one-cycle pulse requesting the row sum.
- sum_valid  in  1  row sum is available, single cycle.
- sum_data  in  ROW_SUM_WIDTH  row sum.
- row_index  out  POS_WIDTH  row currently being swept.
- count_done  out  1  level; total is final.
- count_value  out  RESULT_WIDTH  accumulated total.

Behaviour:
- Reset (asynchronous, reset_n low):
  - State goes to IDLE.
  - All outputs are 0; row_index = 0.
  - Takes effect mid-sweep from any state; no in-flight span or sum is completed.
- States: IDLE, REWIND, REWIND_WAIT, CLEAR, CLEAR_WAIT, FETCH, ISSUE, SUM_REQ, SUM_WAIT, DONE.
- IDLE/DONE + start:
  - count_value <= 0, count_done <= 0, row_index <= 0.
  - Next state: REWIND.
- REWIND: instr_rewind = 1 for exactly one cycle. REWIND_WAIT lasts one cycle so the buffer can reload; then go to CLEAR.
- CLEAR: row_clear = 1 for one cycle, then CLEAR_WAIT until row_idle = 1, then FETCH.
- FETCH:
  - instr_ready = 1 only in this state.
  - On a handshake, compute ylo = min(y_start, y_end), yhi = max(y_start, y_end), xlo = min(x_start, x_end), xhi = max(x_start, x_end).
  - If ylo <= row_index <= yhi and op != 3: latch op, xlo, xhi and instr_last, then go to ISSUE.
  - Otherwise (no match, or op 3 which is reserved): drop the beat. If instr_last, go to SUM_REQ; else stay in FETCH.
- ISSUE:
  - span_valid = 1 while in this state.
  - span_op, span_x_lo and span_x_hi hold the latched values and stay stable while span_ready = 0.
  - On handshake: go to SUM_REQ if the latched last flag is set, else back to FETCH.
  - Throughput: at most one span every 2 cycles.
- SUM_REQ:
  - Waits until row_idle = 1, then pulses sum_req for one cycle and goes to SUM_WAIT.
- SUM_WAIT: on sum_valid, add zero-extended sum_data to count_value (modulo 2^RESULT_WIDTH unless the optional feature is compiled in). Then:
  - if row_index == GRID_SIZE-1: go to DONE and set count_done = 1;
  - else: row_index += 1 and go to REWIND.
- DONE: count_done and count_value hold until reset or the next start.
- Simultaneous events:
  - start outside IDLE/DONE is ignored.
  - sum_valid outside SUM_WAIT is ignored.
  - instr_valid outside FETCH is not acknowledged.
- Each replay must end with an instr_last beat. An instruction list with no last beat stalls in FETCH; this is acceptable and is not a deadlock-free case.

Optional Feature:
- Macro: ROW_SWEEP_SATURATE_EN.
- Defined: the accumulation saturates at all-ones, and an internal sticky overflow bit ORs into bit 0 of a debug-only signal.
- Undefined: the accumulation wraps modulo 2^RESULT_WIDTH.
- All other behaviour is identical in both builds.

Test Plan:
- Smoke: GRID_SIZE=4, single instruction "on 0,0..2,1" with last, stub sum = 3 for rows 0-1 and 0 otherwise.
  -> Spans (1,0,2) on rows 0 and 1 only; 4 rewinds; count_value = 6; count_done = 1.
- Backpressure: hold span_ready low for 5 cycles during ISSUE.
  -> span_valid stays 1 and the span fields are unchanged; exactly one span is accepted.
- Filter and normalisation: op 3, and a toggle with y_start=3, y_end=1, x_start=5, x_end=2, GRID_SIZE=4.
  -> The op 3 beat never produces a span; the toggle issues span (2,2,5) on rows 1-3 only.
- Start handling: start during FETCH -> ignored. Start after DONE -> count_done falls on the next cycle, total is recomputed identically, and row_index restarts at 0.
- Reset mid-sweep: reset_n low while span_valid = 1.
  -> All outputs are 0 immediately; after release the block stays in IDLE with no rewind until start.
- Accumulation limit: RESULT_WIDTH=8, GRID_SIZE=2, sum_data = 200 on both rows.
  -> count_value = 144 without the macro; 255 with ROW_SWEEP_SATURATE_EN.
